pwls_channel_scheduler: RTL and testbench

//  Time-multiplexes one pwls_channel_ALU_unit across NUM_CHANNELS voices. On each sample_tick it runs a fixed
//  per-channel micro-sequence (load regs, phase, shape, scale, accumulate) and then hands the mixed sample downstream.
//  It also owns the single-port channel register file, arbitrating host writes against scheduler reads.

---
 rtl/pwls_sched_pkg.sv | 18 +
 rtl/pwls_rf_port_arbiter.sv | 18 +
 rtl/pwls_channel_scheduler.sv | 92 +++++++++
 tb/tb_pwls_channel_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pwls_sched_pkg.sv
// pwls_sched_pkg: shared FSM states, ALU micro-op codes and frame constants
package pwls_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PHASE, SHAPE, SCALE, ACCUM, DONE} state_t;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PHASE = 3'd1,
    OP_SHAPE = 3'd2,
    OP_SCALE = 3'd3,
    OP_ACCUM = 3'd4
  } alu_op_t;
  localparam int STAGES_PER_CH = 5;
  function automatic alu_op_t op_of(state_t s);
    return s == PHASE ? OP_PHASE :
           s == SHAPE ? OP_SHAPE :
           s == SCALE ? OP_SCALE :
           s == ACCUM ? OP_ACCUM : OP_NOP;
  endfunction
endpackage

// File: rtl/pwls_rf_port_arbiter.sv
// pwls_rf_port_arbiter: shares the single register-file port between scheduler reads and host writes
module pwls_rf_port_arbiter #(
  parameter int CH_BITS = 2
) (
  input  logic               sched_load_i,
  input  logic [CH_BITS-1:0] sched_chan_i,
  input  logic               wr_req_i,
  input  logic [CH_BITS-1:0] wr_chan_i,
  output logic               wr_ack_o,
  output logic               rf_wr_en_o,
  output logic               rf_rd_en_o,
  output logic [CH_BITS-1:0] rf_chan_o
);
  assign wr_ack_o   = wr_req_i & ~sched_load_i;
  assign rf_wr_en_o = wr_ack_o;
  assign rf_rd_en_o = sched_load_i;
  assign rf_chan_o  = wr_ack_o ? wr_chan_i : sched_chan_i;
endmodule

// File: rtl/pwls_channel_scheduler.sv
// pwls_channel_scheduler: per-frame micro-sequencer sharing one ALU across all voices
module pwls_channel_scheduler
  import pwls_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int REG_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic [NUM_CHANNELS-1:0] chan_enable,
  output logic                    rf_rd_en,
  output logic [CH_BITS-1:0]      rf_chan,
  output logic                    rf_wr_en,
  input  logic                    wr_req,
  input  logic [CH_BITS-1:0]      wr_chan,
  input  logic [REG_BITS-1:0]     wr_reg,
  output logic                    wr_ack,
  output logic                    alu_en,
  output logic [2:0]              alu_op,
  output logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
);
  state_t             state_q, state_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic               en_q, en_d;
  logic               overrun_q, overrun_d;
  logic               last_ch;
  // The register index travels to the register file directly; nothing here decodes it.
  logic               unused_wr_reg;
  assign unused_wr_reg = ^wr_reg;
  assign last_ch = ch_q == CH_BITS'(NUM_CHANNELS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      en_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      en_q      <= en_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    en_d    = en_q;
    case (state_q)
      IDLE:    state_d = sample_tick ? LOAD : IDLE;
      LOAD: begin
        state_d = PHASE;
        en_d    = chan_enable[ch_q];
      end
      PHASE:   state_d = SHAPE;
      SHAPE:   state_d = SCALE;
      SCALE:   state_d = ACCUM;
      ACCUM: begin
        state_d = last_ch ? DONE : LOAD;
        ch_d    = last_ch ? '0 : ch_q + CH_BITS'(1);
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // A dropped tick wins over a same-cycle clear so no overrun is ever lost.
    overrun_d = (sample_tick && state_q != IDLE) || (overrun_q && !overrun_clr);
  end
  always_comb begin
    alu_op    = op_of(state_q);
    alu_en    = (alu_op != OP_NOP) && en_q;
    acc_clear = (state_q == LOAD) && (ch_q == '0);
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    overrun   = overrun_q;
  end
  pwls_rf_port_arbiter #(.CH_BITS(CH_BITS)) u_arb (
    .sched_load_i (state_q == LOAD),
    .sched_chan_i (ch_q),
    .wr_req_i     (wr_req),
    .wr_chan_i    (wr_chan),
    .wr_ack_o     (wr_ack),
    .rf_wr_en_o   (rf_wr_en),
    .rf_rd_en_o   (rf_rd_en),
    .rf_chan_o    (rf_chan)
  );
endmodule

// File: tb/tb_pwls_channel_scheduler.sv
// tb_pwls_channel_scheduler: directed + random stimulus against a frame-offset reference model
module tb_pwls_channel_scheduler;
  localparam int NC = 4;
  localparam int CB = 2;
  localparam int RB = 3;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic [NC-1:0] chan_enable = '1;
  logic          wr_req = 1'b0;
  logic [CB-1:0] wr_chan = '0;
  logic [RB-1:0] wr_reg = '0;
  logic          out_ready = 1'b1;
  logic          overrun_clr = 1'b0;
  logic          rf_rd_en, rf_wr_en, wr_ack, alu_en, acc_clear, out_valid, busy, overrun;
  logic [CB-1:0] rf_chan;
  logic [2:0]    alu_op;
  int passed = 0, failed = 0, total = 0, cyc = 0, tick_cyc = 0;
  logic prev_valid = 1'b0;
  int m_phase = 0;
  int m_k = 0;
  bit m_en = 1'b0;
  bit m_ovr = 1'b0;

  pwls_channel_scheduler #(.NUM_CHANNELS(NC), .REG_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .chan_enable(chan_enable),
    .rf_rd_en(rf_rd_en), .rf_chan(rf_chan), .rf_wr_en(rf_wr_en),
    .wr_req(wr_req), .wr_chan(wr_chan), .wr_reg(wr_reg), .wr_ack(wr_ack),
    .alu_en(alu_en), .alu_op(alu_op), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs follow from the offset within the frame: channel = k/5, stage = k%5.
  task automatic check_all();
    int  ch  = (m_phase == 1) ? m_k / 5 : 0;
    int  s   = (m_phase == 1) ? m_k % 5 : 0;
    bit  ld  = (m_phase == 1) && (s == 0);
    bit  ack = wr_req && !ld;
    chk("rf_rd_en", rf_rd_en, ld);
    chk("wr_ack", wr_ack, ack);
    chk("rf_wr_en", rf_wr_en, ack);
    chk("rf_chan", rf_chan, ack ? wr_chan : ch);
    chk("alu_en", alu_en, (m_phase == 1) && (s != 0) && m_en);
    chk("alu_op", alu_op, s);
    chk("acc_clear", acc_clear, (m_phase == 1) && (m_k == 0));
    chk("out_valid", out_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic step(input bit tick, input logic [NC-1:0] en, input bit wr,
                      input logic [CB-1:0] wch, input bit rdy, input bit oclr);
    @(negedge clk);
    sample_tick = tick; chan_enable = en; wr_req = wr; wr_chan = wch;
    out_ready = rdy; overrun_clr = oclr; wr_reg = RB'($urandom);
    #1;
    check_all();
    if (out_valid && !prev_valid) chk("frame_len", cyc - tick_cyc, 1 + 5 * NC);
    prev_valid = out_valid;
    @(posedge clk);
    if (sample_tick && m_phase != 0) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    case (m_phase)
      0: if (sample_tick) begin m_phase = 1; m_k = 0; tick_cyc = cyc; end
      1: begin
        if (m_k % 5 == 0) m_en = chan_enable[m_k / 5];
        m_k++;
        if (m_k == 5 * NC) m_phase = 2;
      end
      default: if (out_ready) m_phase = 0;
    endcase
    cyc++;
  endtask

  task automatic idle(input int n, input logic [NC-1:0] en, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sample_tick = 1'b0; wr_req = 1'b0; overrun_clr = 1'b0;
    #1;
    m_phase = 0; m_k = 0; m_ovr = 1'b0; m_en = 1'b0;
    check_all();
    prev_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle(2, 4'hF, 1'b1);
    // all channels enabled, full frame with immediate acceptance
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b0);
    idle(24, 4'hF, 1'b1);
    // channels 1 and 3 disabled: same timing, no ALU activity for them
    step(1'b1, 4'b0101, 1'b0, '0, 1'b1, 1'b0);
    idle(24, 4'b0101, 1'b1);
    // downstream stalls in DONE; a tick meanwhile is dropped and flagged
    step(1'b1, 4'hF, 1'b0, '0, 1'b0, 1'b0);
    idle(25, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0, '0, 1'b0, 1'b0);
    idle(3, 4'hF, 1'b0);
    step(1'b0, 4'hF, 1'b0, '0, 1'b0, 1'b1);
    idle(3, 4'hF, 1'b1);
    // host write: stalled during LOAD, immediate otherwise
    step(1'b0, 4'hF, 1'b1, 2'd2, 1'b1, 1'b0);
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 4'hF, 1'b1, 2'd3, 1'b1, 1'b0);
    step(1'b0, 4'hF, 1'b1, 2'd3, 1'b1, 1'b0);
    idle(4, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b1, 2'd1, 1'b1, 1'b0);
    idle(16, 4'hF, 1'b1);
    // abort during SCALE of channel 2, then a clean frame from channel 0
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b0);
    idle(13, 4'hF, 1'b1);
    do_reset();
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b0);
    idle(24, 4'hF, 1'b1);
    // tick and clear together while busy: the set wins
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 4'hF, 1'b1);
    step(1'b1, 4'hF, 1'b0, '0, 1'b1, 1'b1);
    idle(22, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b0, '0, 1'b1, 1'b1);
    idle(2, 4'hF, 1'b1);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 11) == 0, NC'($urandom), $urandom_range(0, 2) == 0,
           CB'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
